// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, mid-bit sampling.
//
// This is the receive half of the team's UART pair. It uses the same
// CLKS_PER_BIT convention as the transmitter, so the two can be wired
// together directly in loopback.
//
// Optional feature: when the macro RX_PARITY_EN is defined, the frame
// becomes 8E1. A PARITY state is added and the o_RX_Parity_Err output
// appears.
//
// Ports:
//   i_Clock          system clock; all logic runs on the rising edge
//   i_Rst_L          asynchronous active-low reset
//   i_RX_Serial      asynchronous serial line, idles high
//   o_RX_DV          one-cycle strobe; o_RX_Byte is valid in that cycle
//   o_RX_Byte        last good byte, held until the next good byte
//   o_RX_Busy        high whenever the FSM is not in IDLE
//   o_RX_Frame_Err   one-cycle strobe when the stop bit samples 0
//   o_RX_Parity_Err  (RX_PARITY_EN only) one-cycle strobe on bad parity
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line idle; waiting for rx_s to fall
// START     | counting to the middle of the start bit to confirm it
// DATA      | sampling 8 data bits at mid-bit, LSB first
// PARITY    | (RX_PARITY_EN) sampling the even-parity bit at mid-bit
// STOP      | sampling the stop bit; raises the DV or error strobe
// CLEANUP   | one cycle to let the strobes drop before IDLE
// WAIT_HIGH | stop bit was 0; hold here until the line goes high

module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Busy,
  output logic       o_RX_Frame_Err
`ifdef RX_PARITY_EN
  ,
  output logic       o_RX_Parity_Err
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CLEANUP,
    S_WAIT_HIGH
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       rx_byte, byte_nxt;
  logic             dv, dv_nxt;
  logic             ferr, ferr_nxt;
  logic             rx_meta, rx_s;
`ifdef RX_PARITY_EN
  logic             par_bit, par_nxt;
  logic             perr, perr_nxt;
`endif

  // Two-flop synchroniser. Both flops reset high so that a reset never
  // looks like a start bit.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      rx_byte <= '0;
      dv      <= 1'b0;
      ferr    <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit <= 1'b0;
      perr    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      rx_byte <= byte_nxt;
      dv      <= dv_nxt;
      ferr    <= ferr_nxt;
`ifdef RX_PARITY_EN
      par_bit <= par_nxt;
      perr    <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    byte_nxt  = rx_byte;
    // The strobes default low every cycle, so each one lasts exactly one cycle.
    dv_nxt    = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef RX_PARITY_EN
    par_nxt   = par_bit;
    perr_nxt  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF_CNT) begin
          cnt_nxt = '0;
          // The line is high again at mid start bit, so treat it as a glitch.
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == 3'd7) begin
            idx_nxt = '0;
`ifdef RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          par_nxt   = rx_s;
          state_nxt = S_STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            // A framing error takes precedence over a parity error.
            ferr_nxt  = 1'b1;
            state_nxt = S_WAIT_HIGH;
`ifdef RX_PARITY_EN
          end else if (^{shift, par_bit}) begin
            perr_nxt  = 1'b1;
            state_nxt = S_CLEANUP;
`endif
          end else begin
            byte_nxt  = shift;
            dv_nxt    = 1'b1;
            state_nxt = S_CLEANUP;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_CLEANUP: state_nxt = S_IDLE;
      S_WAIT_HIGH: begin
        // A break or a stuck-low line must not be parsed as a stream of frames.
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_RX_DV        = dv;
  assign o_RX_Byte      = rx_byte;
  assign o_RX_Busy      = (state != S_IDLE);
  assign o_RX_Frame_Err = ferr;
`ifdef RX_PARITY_EN
  assign o_RX_Parity_Err = perr;
`endif

endmodule
